// File: rtl/ahb_matrix_input_stage.sv
// rtl/ahb_matrix_input_stage.sv - AHB bus-matrix slave-port input stage with address holding register
// Optional feature: define INPUT_STAGE_HOLD_STATS_EN to enable the hold_cycles counter.
module ahb_matrix_input_stage (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [3:0]  HPROTS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS,
  output logic        sel_dec,
  output logic [21:0] decode_addr_dec,
  output logic [1:0]  trans_dec,
  output logic [31:0] addr_in,
  output logic        write_in,
  output logic [2:0]  size_in,
  output logic [3:0]  prot_in,
  input  logic        active_dec,
  input  logic        readyout_dec,
  input  logic [1:0]  resp_dec,
  output logic        held_tran,
  output logic [15:0] hold_cycles
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        take;
  logic        capture;

  logic [31:0] hold_addr;
  logic [1:0]  hold_trans;
  logic        hold_write;
  logic [2:0]  hold_size;
  logic [3:0]  hold_prot;

  assign accept  = HSELS & HTRANSS[1] & HREADYS;
  // A new address phase is only considered when no transfer is pending or
  // the current data phase completes this cycle.
  assign capture = take & accept;

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and master-side response; DATA completing behaves exactly like IDLE
  always_comb begin
    state_next = state;
    HREADYOUTS = 1'b1;
    HRESPS     = RESP_OKAY;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        take = 1'b1;
      end
      ST_HELD: begin
        HREADYOUTS = 1'b0;
        if (active_dec) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        HREADYOUTS = readyout_dec;
        HRESPS     = resp_dec;
        if (readyout_dec) begin
          take = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (take) begin
      if (accept) begin
        state_next = active_dec ? ST_DATA : ST_HELD;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // Holding register: captures every accepted address phase, frozen while HELD
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_addr  <= 32'd0;
      hold_trans <= 2'd0;
      hold_write <= 1'b0;
      hold_size  <= 3'd0;
      hold_prot  <= 4'd0;
    end else if (capture) begin
      hold_addr  <= HADDRS;
      hold_trans <= HTRANSS;
      hold_write <= HWRITES;
      hold_size  <= HSIZES;
      hold_prot  <= HPROTS;
    end
  end

  assign held_tran = (state == ST_HELD);

  // Decoder/output-stage mux: holding register while HELD, live master signals otherwise
  always_comb begin
    sel_dec   = HSELS;
    addr_in   = HADDRS;
    trans_dec = HTRANSS;
    write_in  = HWRITES;
    size_in   = HSIZES;
    prot_in   = HPROTS;
    if (held_tran) begin
      sel_dec   = 1'b1;
      addr_in   = hold_addr;
      trans_dec = hold_trans;
      write_in  = hold_write;
      size_in   = hold_size;
      prot_in   = hold_prot;
    end
  end

  assign decode_addr_dec = addr_in[31:10];

`ifdef INPUT_STAGE_HOLD_STATS_EN
  logic [15:0] hold_cnt;

  // Saturating count of cycles spent waiting for a grant
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_cnt <= 16'd0;
    end else if ((state == ST_HELD) && (hold_cnt != 16'hFFFF)) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  assign hold_cycles = hold_cnt;
`else
  assign hold_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_ahb_matrix_input_stage.sv
// tb/tb_ahb_matrix_input_stage.sv - self-checking bench for ahb_matrix_input_stage
module tb_ahb_matrix_input_stage;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [3:0]  HPROTS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_dec;
  logic [21:0] decode_addr_dec;
  logic [1:0]  trans_dec;
  logic [31:0] addr_in;
  logic        write_in;
  logic [2:0]  size_in;
  logic [3:0]  prot_in;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;
  logic        held_tran;
  logic [15:0] hold_cycles;

  int n_vec = 0;
  int n_err = 0;

`ifdef INPUT_STAGE_HOLD_STATS_EN
  localparam int EXP_HOLD3 = 3;
`else
  localparam int EXP_HOLD3 = 0;
`endif

  always #5 HCLK = ~HCLK;

  ahb_matrix_input_stage dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .HSELS           (HSELS),
    .HADDRS          (HADDRS),
    .HTRANSS         (HTRANSS),
    .HWRITES         (HWRITES),
    .HSIZES          (HSIZES),
    .HPROTS          (HPROTS),
    .HREADYS         (HREADYS),
    .HREADYOUTS      (HREADYOUTS),
    .HRESPS          (HRESPS),
    .sel_dec         (sel_dec),
    .decode_addr_dec (decode_addr_dec),
    .trans_dec       (trans_dec),
    .addr_in         (addr_in),
    .write_in        (write_in),
    .size_in         (size_in),
    .prot_in         (prot_in),
    .active_dec      (active_dec),
    .readyout_dec    (readyout_dec),
    .resp_dec        (resp_dec),
    .held_tran       (held_tran),
    .hold_cycles     (hold_cycles)
  );

  // Reference model: a pending (ungranted) transfer, a data-phase flag and a stall counter
  bit          m_pending;
  bit          m_in_data;
  logic [31:0] m_addr;
  logic [1:0]  m_trans;
  logic        m_write;
  logic [2:0]  m_size;
  logic [3:0]  m_prot;
  int          m_stalls;
  logic [84:0] exp_v;

  task automatic model_reset();
    m_pending = 0;
    m_in_data = 0;
    m_addr = 0; m_trans = 0; m_write = 0; m_size = 0; m_prot = 0;
    m_stalls = 0;
  endtask

  task automatic model_expect();
    logic        r;
    logic [1:0]  rs;
    if (m_pending) begin
      r = 1'b0; rs = 2'b00;
      exp_v = {r, rs, 1'b1, m_addr[31:10], m_trans, m_addr, m_write, m_size, m_prot, 1'b1, m_stalls[15:0]};
    end else begin
      if (m_in_data) begin r = readyout_dec; rs = resp_dec; end
      else begin r = 1'b1; rs = 2'b00; end
      exp_v = {r, rs, HSELS, HADDRS[31:10], HTRANSS, HADDRS, HWRITES, HSIZES, HPROTS, 1'b0, m_stalls[15:0]};
    end
  endtask

  task automatic model_edge();
    bit acc;
    acc = HSELS && HTRANSS[1] && HREADYS;
    if (HRESET) begin
      model_reset();
    end else begin
`ifdef INPUT_STAGE_HOLD_STATS_EN
      if (m_pending && m_stalls < 65535) m_stalls = m_stalls + 1;
`endif
      if (m_pending) begin
        if (active_dec) begin m_pending = 0; m_in_data = 1; end
      end else if (!m_in_data || readyout_dec) begin
        if (acc) begin
          m_addr = HADDRS; m_trans = HTRANSS; m_write = HWRITES; m_size = HSIZES; m_prot = HPROTS;
          m_in_data = active_dec;
          m_pending = !active_dec;
        end else begin
          m_in_data = 0;
        end
      end
    end
  endtask

  function automatic logic [84:0] dut_vec();
    return {HREADYOUTS, HRESPS, sel_dec, decode_addr_dec, trans_dec, addr_in, write_in,
            size_in, prot_in, held_tran, hold_cycles};
  endfunction

  task automatic settle();
    @(negedge HCLK);
    model_expect();
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    HRESET = 0; HSELS = 0; HADDRS = 0; HTRANSS = 0; HWRITES = 0; HSIZES = 0; HPROTS = 0;
    HREADYS = 1; active_dec = 0; readyout_dec = 0; resp_dec = 0;
  endtask

  task automatic do_reset();
    set_idle();
    HRESET = 1;
    tick();
    HRESET = 0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", HREADYOUTS); end
    n_vec++; if (HRESPS !== 2'b00) begin n_err++; $display("FAIL reset_resp got %0d want 0", HRESPS); end
    n_vec++; if (held_tran !== 1'b0) begin n_err++; $display("FAIL reset_held got %0b want 0", held_tran); end
    n_vec++; if (hold_cycles !== 16'd0) begin n_err++; $display("FAIL reset_hold_cycles got %0d want 0", hold_cycles); end
    n_vec++; if ({dut.hold_addr, dut.hold_trans, dut.hold_write, dut.hold_size, dut.hold_prot} !== 42'd0) begin
      n_err++; $display("FAIL reset_holdreg got %h want 0", dut.hold_addr); end
    tick();
  endtask

  task automatic test_granted();
    set_idle();
    HSELS = 1; HTRANSS = 2'b10; HADDRS = 32'h0000_0100; HWRITES = 1; HSIZES = 3'd2; HPROTS = 4'h3;
    active_dec = 1; readyout_dec = 1;
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1 || held_tran !== 1'b0) begin n_err++;
      $display("FAIL granted_addr_phase got rdy=%0b held=%0b want rdy=1 held=0", HREADYOUTS, held_tran); end
    n_vec++; if (addr_in !== 32'h100 || write_in !== 1'b1 || decode_addr_dec !== 22'd0) begin n_err++;
      $display("FAIL granted_live_addr got %h want 00000100", addr_in); end
    tick();
    set_idle(); readyout_dec = 1;
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1 || held_tran !== 1'b0) begin n_err++;
      $display("FAIL granted_data_phase got rdy=%0b held=%0b want rdy=1 held=0", HREADYOUTS, held_tran); end
    n_vec++; if (dut_vec() !== exp_v) begin n_err++; $display("FAIL granted_model got %h want %h", dut_vec(), exp_v); end
    tick();
  endtask

  task automatic test_held();
    do_reset();
    HSELS = 1; HTRANSS = 2'b10; HADDRS = 32'h0000_2000; HWRITES = 0; HSIZES = 3'd2; HPROTS = 4'h1;
    HREADYS = 1; active_dec = 0;
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1 || held_tran !== 1'b0) begin n_err++;
      $display("FAIL held_addr_phase got rdy=%0b held=%0b want rdy=1 held=0", HREADYOUTS, held_tran); end
    tick();
    for (int i = 0; i < 3; i++) begin
      HSELS = 0; HTRANSS = 2'b00; HADDRS = $urandom; HREADYS = 0; active_dec = (i == 2);
      settle();
      n_vec++; if (held_tran !== 1'b1 || HREADYOUTS !== 1'b0 || sel_dec !== 1'b1) begin n_err++;
        $display("FAIL held_cycle%0d got held=%0b rdy=%0b sel=%0b want 1 0 1", i, held_tran, HREADYOUTS, sel_dec); end
      n_vec++; if (addr_in !== 32'h0000_2000 || trans_dec !== 2'b10 || decode_addr_dec !== 22'd8) begin n_err++;
        $display("FAIL held_addr%0d got %h want 00002000", i, addr_in); end
      tick();
    end
    set_idle(); readyout_dec = 1;
    settle();
    n_vec++; if (held_tran !== 1'b0 || HREADYOUTS !== 1'b1) begin n_err++;
      $display("FAIL held_to_data got held=%0b rdy=%0b want 0 1", held_tran, HREADYOUTS); end
    n_vec++; if (hold_cycles !== 16'(EXP_HOLD3)) begin n_err++;
      $display("FAIL held_count got %0d want %0d", hold_cycles, EXP_HOLD3); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_idle();
    HSELS = 1; HTRANSS = 2'b10; HADDRS = 32'h10; active_dec = 1; readyout_dec = 1;
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1 || addr_in !== 32'h10) begin n_err++;
      $display("FAIL b2b_first got rdy=%0b addr=%h want 1 00000010", HREADYOUTS, addr_in); end
    tick();
    HTRANSS = 2'b11; HADDRS = 32'h14;
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1 || held_tran !== 1'b0 || addr_in !== 32'h14) begin n_err++;
      $display("FAIL b2b_second got rdy=%0b held=%0b addr=%h want 1 0 00000014", HREADYOUTS, held_tran, addr_in); end
    tick();
    set_idle(); readyout_dec = 1;
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1 || dut_vec() !== exp_v) begin n_err++;
      $display("FAIL b2b_last_data got %h want %h", dut_vec(), exp_v); end
    tick();
    readyout_dec = 0;
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL b2b_back_idle got rdy=%0b want 1", HREADYOUTS); end
    tick();
  endtask

  task automatic test_error();
    set_idle();
    HSELS = 1; HTRANSS = 2'b10; HADDRS = 32'h40; active_dec = 1; readyout_dec = 1;
    settle();
    tick();
    set_idle(); readyout_dec = 0; resp_dec = 2'b01;
    settle();
    n_vec++; if (HRESPS !== 2'b01 || HREADYOUTS !== 1'b0) begin n_err++;
      $display("FAIL err_first got resp=%0d rdy=%0b want 1 0", HRESPS, HREADYOUTS); end
    tick();
    readyout_dec = 1;
    settle();
    n_vec++; if (HRESPS !== 2'b01 || HREADYOUTS !== 1'b1) begin n_err++;
      $display("FAIL err_second got resp=%0d rdy=%0b want 1 1", HRESPS, HREADYOUTS); end
    tick();
    readyout_dec = 0; resp_dec = 2'b00;
    settle();
    n_vec++; if (HRESPS !== 2'b00 || HREADYOUTS !== 1'b1 || held_tran !== 1'b0) begin n_err++;
      $display("FAIL err_back_idle got resp=%0d rdy=%0b want 0 1", HRESPS, HREADYOUTS); end
    tick();
  endtask

  task automatic test_reset_in_held();
    set_idle();
    HSELS = 1; HTRANSS = 2'b10; HADDRS = 32'hABCD_1234; HPROTS = 4'hF; active_dec = 0;
    settle();
    tick();
    set_idle(); HREADYS = 0; HRESET = 1;
    settle();
    n_vec++; if (held_tran !== 1'b1) begin n_err++; $display("FAIL rsth_entered got held=%0b want 1", held_tran); end
    tick();
    set_idle();
    settle();
    n_vec++; if (held_tran !== 1'b0 || HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin n_err++;
      $display("FAIL rsth_after got held=%0b rdy=%0b resp=%0d want 0 1 0", held_tran, HREADYOUTS, HRESPS); end
    n_vec++; if ({dut.hold_addr, dut.hold_trans, dut.hold_write, dut.hold_size, dut.hold_prot} !== 42'd0) begin
      n_err++; $display("FAIL rsth_holdreg got %h want 0", dut.hold_addr); end
    tick();
  endtask

  task automatic test_idle_busy();
    for (int t = 0; t < 2; t++) begin
      set_idle();
      HSELS = 1; HTRANSS = 2'(t); HADDRS = 32'h0000_0C00; active_dec = 0;
      settle();
      n_vec++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00 || sel_dec !== 1'b1 || trans_dec !== 2'(t)) begin n_err++;
        $display("FAIL idlebusy%0d got rdy=%0b resp=%0d sel=%0b trans=%0d want 1 0 1 %0d",
                 t, HREADYOUTS, HRESPS, sel_dec, trans_dec, t); end
      tick();
    end
    set_idle();
    settle();
    n_vec++; if (HREADYOUTS !== 1'b1 || held_tran !== 1'b0) begin n_err++;
      $display("FAIL idlebusy_stay got rdy=%0b held=%0b want 1 0", HREADYOUTS, held_tran); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      HRESET       = ($urandom_range(0, 59) == 0);
      HSELS        = ($urandom_range(0, 3) != 0);
      HADDRS       = $urandom;
      HTRANSS      = 2'($urandom_range(0, 3));
      HWRITES      = 1'($urandom_range(0, 1));
      HSIZES       = 3'($urandom_range(0, 7));
      HPROTS       = 4'($urandom_range(0, 15));
      HREADYS      = ($urandom_range(0, 3) != 0);
      active_dec   = ($urandom_range(0, 2) != 0);
      readyout_dec = ($urandom_range(0, 2) != 0);
      resp_dec     = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
      settle();
      n_vec++; if (dut_vec() !== exp_v) begin n_err++;
        $display("FAIL random_c%0d got %h want %h", c, dut_vec(), exp_v); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_granted();
    test_held();
    test_back_to_back();
    test_error();
    test_reset_in_held();
    test_idle_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_matrix_input_stage.md
AHB_MATRIX_INPUT_STAGE -- requirements
Module: ahb_matrix_input_stage

Interface
REQ-001 Clock and reset SHALL be: one clock, HCLK; reset HRESET, synchronous and active-high.
REQ-002 HCLK  in  1  AHB system clock.
REQ-003 HRESET  in  1  synchronous active-high reset.
REQ-004 HSELS  in  1  slave-port select from master.
REQ-005 HADDRS  in  32  master address.
REQ-006 HTRANSS  in  2  master transfer type.
REQ-007 HWRITES / HSIZES / HPROTS  in  1/3/4  master control.
REQ-008 HREADYS  in  1  slave-port HREADY (transfer done).
REQ-009 HREADYOUTS  out  1  ready returned to master.
REQ-010 HRESPS  out  2  response returned to master.
REQ-011 sel_dec  out  1  select to decoder.
REQ-012 decode_addr_dec  out  22  address[31:10] to decoder.
REQ-013 trans_dec  out  2  transfer type to decoder and output stages.
REQ-014 addr_in / write_in / size_in / prot_in  out  32/1/3/4  muxed address and control to output stages.
REQ-015 active_dec  in  1  decoder: addressed output stage grants this port.
REQ-016 readyout_dec / resp_dec  in  1/2  decoder: data-phase ready and response.
REQ-017 held_tran  out  1  high while the holding register drives the outputs.
REQ-018 hold_cycles  out  16  HELD-cycle count (see Configuration).

Function
REQ-019 accept SHALL be HSELS & HTRANSS[1] & HREADYS.
REQ-020 The block SHALL implement states IDLE, HELD, DATA, held in a 2-bit register.
REQ-021 On accept, the holding register SHALL capture HADDRS, HTRANSS, HWRITES, HSIZES and HPROTS.
REQ-022 held_tran SHALL equal (state==HELD); when high, all decoder/output-stage outputs SHALL come from the holding register and sel_dec SHALL be 1; otherwise they SHALL be the live master signals, with sel_dec=HSELS.
REQ-023 IDLE: HREADYOUTS=1, HRESPS=OKAY; accept&active_dec -> DATA; accept&~active_dec -> HELD; else stay.
REQ-024 HELD: HREADYOUTS=0, HRESPS=OKAY; active_dec=1 -> DATA that cycle-edge; else stay, holding-register contents unchanged.
REQ-025 DATA: HREADYOUTS=readyout_dec, HRESPS=resp_dec; readyout_dec=0 -> stay.
REQ-026 DATA with readyout_dec=1 SHALL re-evaluate exactly as IDLE in the same cycle (back-to-back transfers, zero bubble).
REQ-027 Two-cycle ERROR (resp_dec=ERROR, readyout_dec 0 then 1) SHALL pass through unmodified; a master IDLE after ERROR SHALL return to IDLE.
REQ-028 IDLE/BUSY transfers SHALL never enter HELD or DATA and SHALL be answered zero-wait OKAY, while still driving sel_dec and trans_dec live.
REQ-029 Latency: granted transfer 0 added cycles; held transfer 1 + grant-wait cycles.

Reset
REQ-030 With HRESET=1 at a rising HCLK edge, state SHALL become IDLE and the holding register SHALL clear to 0.
REQ-031 After reset, outputs SHALL be: HREADYOUTS=1, HRESPS=OKAY, held_tran=0, hold_cycles=0.
REQ-032 Reset mid-HELD or mid-DATA SHALL abandon the transfer with no further response.

Configuration
REQ-033 With INPUT_STAGE_HOLD_STATS_EN defined, hold_cycles SHALL increment once per cycle in HELD, saturate at 16'hFFFF, and clear only on reset.
REQ-034 Without INPUT_STAGE_HOLD_STATS_EN, hold_cycles SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-035 NONSEQ write to 0x0000_0100, active_dec=1, readyout_dec=1 -> IDLE->DATA, HREADYOUTS=1 next cycle, held_tran never 1.
REQ-036 NONSEQ to 0x0000_2000, active_dec=0 for 3 cycles then 1 -> held_tran=1 for 3 cycles, addr_in=0x0000_2000 throughout, HREADYOUTS=0, hold_cycles=3 (macro on) / 0 (macro off).
REQ-037 Back-to-back NONSEQ 0x10 then SEQ 0x14, both granted, readyout_dec=1 -> DATA held two cycles, no wait states.
REQ-038 resp_dec=ERROR with readyout_dec 0 then 1, master then IDLE -> HRESPS=ERROR two cycles, HREADYOUTS 0 then 1, state IDLE.
REQ-039 HRESET=1 asserted during HELD -> next cycle state IDLE, held_tran=0, HREADYOUTS=1, holding register 0.
REQ-040 HSELS=1, HTRANSS=IDLE, active_dec=0 -> HREADYOUTS=1, HRESPS=OKAY, state stays IDLE.
